// File: rtl/seq_pc_pkg.sv
// ============================================================================
// Module      : seq_pc_pkg
// Description : Shared encodings and defaults for the PC sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_pc_pkg;

    localparam int DEF_PC_W  = 8;
    localparam int DEF_OFF_W = 4;
    localparam int DEF_CNT_W = 16;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_FETCH  = 2'b01;
    localparam logic [1:0] ST_EXEC   = 2'b10;
    localparam logic [1:0] ST_HALTED = 2'b11;

    localparam int INC_NORMAL = 1;
    localparam int INC_SKIP   = 2;

endpackage

`default_nettype wire

// File: rtl/proximo_pc.sv
// ============================================================================
// Module      : proximo_pc
// Description : Next-PC selection for EXEC: halt > GT relative > skip > +1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module proximo_pc
    import seq_pc_pkg::*;
#(
    parameter int PC_W  = DEF_PC_W,
    parameter int OFF_W = DEF_OFF_W
) (
    input  logic [PC_W-1:0]  pc,
    input  logic             halt_instr,
    input  logic             gt_en,
    input  logic             gt_sub,
    input  logic [OFF_W-1:0] gt_off,
    input  logic             skip_en,
    input  logic             zero,
    input  logic             neg,
    output logic [PC_W-1:0]  pc_next
);

    logic [PC_W-1:0] w_off;
    logic            w_skip;

    // All arithmetic is naturally modulo 2^PC_W; the offset is zero-extended.
    always_comb begin
        w_off   = PC_W'(gt_off);
        w_skip  = skip_en & (~zero | ~neg);
        pc_next = pc + PC_W'(INC_NORMAL);
        if (halt_instr) begin
            pc_next = pc;
        end else if (gt_en) begin
            pc_next = gt_sub ? (pc - w_off) : (pc + w_off);
        end else if (w_skip) begin
            pc_next = pc + PC_W'(INC_SKIP);
        end
    end

endmodule

`default_nettype wire

// File: rtl/sequenciador_pc.sv
// ============================================================================
// Module      : sequenciador_pc
// Description : Fetch/execute sequencer owning the PC, halt/resume, stepping
//               and a saturating retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sequenciador_pc
    import seq_pc_pkg::*;
#(
    parameter int              PC_W     = DEF_PC_W,
    parameter int              OFF_W    = DEF_OFF_W,
    parameter int              CNT_W    = DEF_CNT_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              resume,
    input  logic              step_mode,
    input  logic              step,
    input  logic              halt_instr,
    input  logic              skip_en,
    input  logic              zero,
    input  logic              neg,
    input  logic              gt_en,
    input  logic              gt_sub,
    input  logic [OFF_W-1:0]  gt_off,
    output logic [PC_W-1:0]   pc,
    output logic              fetch_en,
    output logic              exec_en,
    output logic              halted,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  instr_count
);

    logic [1:0]       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_advance;
    logic [PC_W-1:0]  w_pc_exec;

    proximo_pc #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_proximo_pc (
        .pc         (pc_q),
        .halt_instr (halt_instr),
        .gt_en      (gt_en),
        .gt_sub     (gt_sub),
        .gt_off     (gt_off),
        .skip_en    (skip_en),
        .zero       (zero),
        .neg        (neg),
        .pc_next    (w_pc_exec)
    );

    assign w_advance = ~step_mode | step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                pc_d = RESET_PC;
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (w_advance) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                pc_d = w_pc_exec;
                if (halt_instr) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_FETCH;
                    if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HALTED: begin
                // Resuming steps past the halt instruction the PC still points at.
                if (resume) begin
                    pc_d    = pc_q + PC_W'(INC_NORMAL);
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fetch_en = (state_q == ST_FETCH) && w_advance;
        exec_en  = (state_q == ST_EXEC);
        halted   = (state_q == ST_HALTED);
    end

    assign pc          = pc_q;
    assign state       = state_q;
    assign instr_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_sequenciador_pc.sv
// ============================================================================
// Module      : tb_sequenciador_pc
// Description : Scoreboard bench for sequenciador_pc with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sequenciador_pc;
    import seq_pc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, resume, step_mode, step;
    logic        halt_instr, skip_en, zero, neg, gt_en, gt_sub;
    logic [3:0]  gt_off;
    logic [7:0]  pc;
    logic        fetch_en, exec_en, halted;
    logic [1:0]  state;
    logic [15:0] instr_count;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_cnt = '0;

    sequenciador_pc dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .resume      (resume),
        .step_mode   (step_mode),
        .step        (step),
        .halt_instr  (halt_instr),
        .skip_en     (skip_en),
        .zero        (zero),
        .neg         (neg),
        .gt_en       (gt_en),
        .gt_sub      (gt_sub),
        .gt_off      (gt_off),
        .pc          (pc),
        .fetch_en    (fetch_en),
        .exec_en     (exec_en),
        .halted      (halted),
        .state       (state),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every EXEC cycle must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && exec_en) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_exec: got exec at pc %0h expected none", pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("exec_pc", pc, e.pc);
                check("exec_cnt", instr_count, e.cnt);
                check("exec_fetch_en", fetch_en, 0);
            end
        end
    end

    task automatic wait_state(input logic [1:0] s);
        for (int i = 0; i < 50; i++) begin
            if (state == s) return;
            @(negedge clk);
        end
        n_tests++;
        n_fail++;
        $display("FAIL timeout_state: got %0d expected %0d", state, s);
    endtask

    task automatic instr(input logic h, input logic g, input logic gs, input logic [3:0] off,
                         input logic sk, input logic z, input logic n, input logic [7:0] exp_now);
        wait_state(ST_FETCH);
        check("fetch_en", fetch_en, 1);
        exp_q.push_back('{pc: exp_now, cnt: exp_cnt});
        if (!h) exp_cnt++;
        halt_instr = h; gt_en = g; gt_sub = gs; gt_off = off;
        skip_en = sk; zero = z; neg = n;
        wait_state(ST_EXEC);
    endtask

    task automatic clear_decode();
        halt_instr = 0; gt_en = 0; gt_sub = 0; gt_off = 0;
        skip_en = 0; zero = 0; neg = 0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; start = 0; resume = 0; step_mode = 0; step = 0;
        clear_decode();
        repeat (3) @(negedge clk);
        check("rst_state", state, ST_IDLE);
        check("rst_pc", pc, 8'h00);
        check("rst_cnt", instr_count, 0);
        check("rst_fetch", fetch_en, 0);
        check("rst_exec", exec_en, 0);
        check("rst_halted", halted, 0);
        rst_n = 1;
        repeat (2) @(negedge clk);
        check("idle_hold", state, ST_IDLE);

        // Three plain instructions from reset.
        do_start();
        check("start_fetch", state, ST_FETCH);
        instr(0,0,0,0,0,0,0,8'h00);
        instr(0,0,0,0,0,0,0,8'h01);
        instr(0,0,0,0,0,0,0,8'h02);
        wait_state(ST_FETCH);
        check("plain_pc", pc, 8'h03);
        check("plain_cnt", instr_count, 3);

        // Asynchronous reset in the middle of EXEC.
        @(posedge clk);
        #2;
        check("mid_exec", exec_en, 1);
        rst_n = 0;
        #1;
        check("async_pc", pc, 8'h00);
        check("async_state", state, ST_IDLE);
        check("async_cnt", instr_count, 0);
        check("async_exec", exec_en, 0);
        @(negedge clk);
        rst_n = 1;
        exp_cnt = 0;

        // Wrap, skip, GT and priority vectors.
        do_start();
        instr(0,1,1,2,0,0,0,8'h00);
        instr(0,0,0,0,0,0,0,8'hFE);
        instr(0,0,0,0,1,0,0,8'hFF);
        instr(0,1,1,2,0,0,0,8'h01);
        instr(0,0,0,0,0,0,0,8'hFF);
        instr(0,1,0,15,0,0,0,8'h00);
        instr(0,0,0,0,0,0,0,8'h0F);
        instr(0,0,0,0,1,1,0,8'h10);
        instr(0,1,1,2,0,0,0,8'h12);
        instr(0,0,0,0,1,1,1,8'h10);
        instr(0,1,1,1,0,0,0,8'h11);
        instr(0,0,0,0,1,0,1,8'h10);
        instr(0,1,1,7,0,0,0,8'h12);
        instr(0,1,1,6,0,0,0,8'h0B);
        instr(0,1,1,7,0,0,0,8'h05);
        instr(0,1,0,7,0,0,0,8'hFE);
        instr(0,1,0,15,0,0,0,8'h05);
        instr(0,1,0,1,1,0,0,8'h14);
        instr(0,1,0,0,0,0,0,8'h15);
        instr(0,1,0,11,0,0,0,8'h15);

        // Halt beats GT; start ignored while halted.
        instr(1,1,0,3,0,0,0,8'h20);
        @(negedge clk);
        clear_decode();
        check("halt_state", state, ST_HALTED);
        check("halt_flag", halted, 1);
        check("halt_pc", pc, 8'h20);
        check("halt_cnt", instr_count, 20);
        check("halt_fetch", fetch_en, 0);
        start = 1;
        repeat (3) @(negedge clk);
        start = 0;
        check("halt_ign_start", state, ST_HALTED);
        check("halt_ign_pc", pc, 8'h20);
        resume = 1;
        @(negedge clk);
        resume = 0;
        check("resume_state", state, ST_FETCH);
        check("resume_pc", pc, 8'h21);

        // Single-step: hold, one step, step during EXEC ignored.
        step_mode = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("step_hold_pc", pc, 8'h21);
            check("step_hold_fetch", fetch_en, 0);
        end
        step = 1;
        #1;
        check("step_fetch", fetch_en, 1);
        exp_q.push_back('{pc: 8'h21, cnt: exp_cnt});
        exp_cnt++;
        @(negedge clk);
        check("step_exec", state, ST_EXEC);
        @(negedge clk);
        step = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("step_after_state", state, ST_FETCH);
            check("step_after_pc", pc, 8'h22);
        end
        check("step_cnt", instr_count, exp_cnt);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
